// File: rtl/truth_table_extractor.sv
// truth_table_extractor
//   Sweeps every input minterm onto a combinational function under test, samples its
//   single output and builds the full 2**N_INPUTS-bit truth table. The finished table is
//   compared bit by bit against a reference table latched when the sweep starts.
//
// Ports
//   clk            single clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a sweep (accepted only when idle or done)
//   abort          stop any sweep and return to idle (beats start)
//   expected       reference truth table, latched on start accept
//   x_drv          minterm driven onto the function under test (bit i -> input xi)
//   f_in           output of the function under test
//   busy           high from start accept until the sweep completes
//   done           one-cycle pulse when the table is complete
//   tt_valid       tt_out and compare results valid until next start/abort
//   tt_out         extracted table, tt_out[m] = f(m)
//   match          tt_out equals the latched reference
//   mismatch_cnt   number of differing bits
//   first_mismatch lowest differing minterm (0 when matching)

module truth_table_extractor #(
  parameter int N_INPUTS      = 7,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [2**N_INPUTS-1:0]   expected,
  output logic [N_INPUTS-1:0]      x_drv,
  input  logic                     f_in,
  output logic                     busy,
  output logic                     done,
  output logic                     tt_valid,
  output logic [2**N_INPUTS-1:0]   tt_out,
  output logic                     match,
  output logic [N_INPUTS:0]        mismatch_cnt,
  output logic [N_INPUTS-1:0]      first_mismatch
);

  localparam int TT_BITS = 2**N_INPUTS;
  localparam int SETTLE_LAST_INT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_LAST_INT);
  localparam logic [N_INPUTS-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [N_INPUTS-1:0] idx;
  logic [3:0]          settle_cnt;
  logic [TT_BITS-1:0]  exp_q;
  logic                start_ok;
  logic                sample_miss;

  // A start only counts when no sweep is running and abort is not asserted with it.
  assign start_ok    = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign sample_miss = (state == S_SAMPLE) && (f_in != exp_q[idx]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start_ok) state_next = S_DRIVE;
        S_DRIVE:        state_next = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        S_SETTLE:       if (settle_cnt == SETTLE_LAST) state_next = S_SAMPLE;
        S_SAMPLE:       state_next = (idx == LAST_IDX) ? S_DONE : S_DRIVE;
        default:        state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: minterm index, settle timer, table assembly and compare bookkeeping.
  // match is taken from the count including the final sample's mismatch, since
  // mismatch_cnt itself only updates on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_drv          <= '0;
      idx            <= '0;
      settle_cnt     <= '0;
      exp_q          <= '0;
      tt_out         <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tt_valid       <= 1'b0;
      match          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy       <= 1'b0;
        tt_valid   <= 1'b0;
        match      <= 1'b0;
        x_drv      <= '0;
        idx        <= '0;
        settle_cnt <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_ok) begin
              exp_q          <= expected;
              tt_out         <= '0;
              mismatch_cnt   <= '0;
              first_mismatch <= '0;
              idx            <= '0;
              tt_valid       <= 1'b0;
              match          <= 1'b0;
              busy           <= 1'b1;
            end
          end
          S_DRIVE: begin
            x_drv      <= idx;
            settle_cnt <= '0;
          end
          S_SETTLE: begin
            settle_cnt <= settle_cnt + 4'd1;
          end
          S_SAMPLE: begin
            tt_out[idx] <= f_in;
            if (sample_miss) begin
              mismatch_cnt <= mismatch_cnt + (N_INPUTS+1)'(1);
              if (mismatch_cnt == '0) first_mismatch <= idx;
            end
            if (idx == LAST_IDX) begin
              done     <= 1'b1;
              busy     <= 1'b0;
              tt_valid <= 1'b1;
              match    <= (mismatch_cnt == '0) && !sample_miss;
            end else begin
              idx <= idx + N_INPUTS'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
